// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one shared full-adder stage, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             overflow_out,
`endif
  output logic             done_out
);

  // state  | meaning
  // S_IDLE | waiting for start_in; ready_out high
  // S_RUN  | one operand bit per clock through the full adder
  // S_DONE | result registers just loaded; done_out pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cy;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_psum_nxt;

  assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_cy;
  assign w_co   = (r_a_sh[0] & r_b_sh[0]) | (r_cy & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so the LSB-first result ends up aligned after WIDTH shifts.
  always_comb begin
    w_psum_nxt            = r_psum >> 1;
    w_psum_nxt[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_out   = 1'b0;
    done_out    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_out = 1'b1;
        if (start_in) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_out    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_psum  <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= a_in;
      r_b_sh <= b_in;
      r_cy   <= c_in;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_psum <= w_psum_nxt;
      r_cy   <= w_co;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum   <= w_psum_nxt;
        r_carry <= w_co;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the final bit r_cy is the carry into the MSB and w_co the carry out of it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                        r_ovf <= 1'b0;
    else if ((r_state == S_RUN) && w_last) r_ovf <= r_cy ^ w_co;
  end

  assign overflow_out = r_ovf;
`endif

  assign sum_out   = r_sum;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n_in;
  logic             start_in;
  logic [WIDTH-1:0] a_in, b_in;
  logic             c_in;
  logic             ready_out, carry_out, done_out;
  logic [WIDTH-1:0] sum_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             overflow_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int acc_cyc = 0;
  bit mon_en  = 1'b0;
  logic [WIDTH-1:0] m_sum   = '0;
  logic             m_carry = 1'b0;
  logic             m_ovf   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .start_in(start_in),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .ready_out(ready_out), .sum_out(sum_out), .carry_out(carry_out),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow_out(overflow_out),
`endif
    .done_out(done_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  // Signed overflow: the true two's-complement sum falls outside the w-bit signed range.
  function automatic bit ref_ovf(input int w, input longint a, b, c);
    longint lim, sa, sb, t;
    lim = longint'(1) << (w - 1);
    sa  = (a >= lim) ? a - 2 * lim : a;
    sb  = (b >= lim) ? b - 2 * lim : b;
    t   = sa + sb + c;
    return (t > lim - 1) || (t < -lim);
  endfunction

  // Outputs must hold the last completed result whenever no done pulse is present.
  always @(negedge clk) begin
    if (mon_en && rst_n_in) begin
      if (done_out) n_done++;
      else begin
        chk("sum_hold", sum_out, m_sum);
        chk("carry_hold", carry_out, m_carry);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf_hold", overflow_out, m_ovf);
`endif
      end
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] a, b, input logic c, input bit hold, input bit poke);
    int n;
    logic [WIDTH:0] e;
    n = 0;
    while (!ready_out && n < 3 * WIDTH + 10) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", ready_out, 1);
    start_in = 1'b1; a_in = a; b_in = b; c_in = c;
    @(posedge clk); #1;
    acc_cyc = cyc;
    chk("busy_after_accept", ready_out, 0);
    if (!hold) start_in = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); c_in = 1'($urandom);
    n = 0;
    while (n <= WIDTH + 4) begin
      @(posedge clk); #1; n++;
      if (done_out) break;
      if (poke && n == 2) begin start_in = 1'b1; a_in = 8'h01; b_in = 8'h02; end
      if (poke && n == 3) start_in = 1'b0;
    end
    chk("latency", n, WIDTH);
    e = ref_add(a, b, c);
    chk("sum", sum_out, e[WIDTH-1:0]);
    chk("carry", carry_out, e[WIDTH]);
    m_sum = e[WIDTH-1:0]; m_carry = e[WIDTH];
`ifdef SERIAL_ADDER_OVF_EN
    m_ovf = ref_ovf(WIDTH, longint'(a), longint'(b), longint'(c));
    chk("overflow", overflow_out, m_ovf);
`endif
    @(posedge clk); #1;
    chk("done_single", done_out, 0);
    chk("ready_back", ready_out, 1);
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  logic s1_start, s1_a, s1_b, s1_c;
  logic r1_ready, r1_sum, r1_carry, r1_done, r1_ovf;
  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n_in), .start_in(s1_start),
    .a_in(s1_a), .b_in(s1_b), .c_in(s1_c),
    .ready_out(r1_ready), .sum_out(r1_sum), .carry_out(r1_carry),
    .overflow_out(r1_ovf), .done_out(r1_done)
  );
  initial begin s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_c = 1'b0; end
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, prev;
    logic [WIDTH:0] e;
    rst_n_in = 1'b0; start_in = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    #12;
    chk("rst_ready", ready_out, 1);
    chk("rst_sum", sum_out, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_done", done_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", overflow_out, 0);
`endif
    @(posedge clk); #1;
    rst_n_in = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_op(8'h5A, 8'h33, 1'b0, 0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 0);

    d0 = n_done;
    run_op(8'h10, 8'h20, 1'b0, 0, 1);
    repeat (WIDTH + 4) begin @(posedge clk); #1; end
    chk("busy_one_pulse", n_done - d0, 1);
    chk("busy_result", sum_out, 8'h30);

    prev = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1, 0);
      if (i > 0) chk("b2b_spacing", acc_cyc - prev, WIDTH + 2);
      prev = acc_cyc;
    end
    start_in = 1'b0;

    start_in = 1'b1; a_in = 8'hAA; b_in = 8'h55; c_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    d0 = n_done;
    rst_n_in = 1'b0;
    m_sum = '0; m_carry = 1'b0; m_ovf = 1'b0;
    #1;
    chk("midrst_ready", ready_out, 1);
    chk("midrst_sum", sum_out, 0);
    chk("midrst_carry", carry_out, 0);
    chk("midrst_done", done_out, 0);
    @(posedge clk); #1;
    rst_n_in = 1'b1;
    repeat (WIDTH + 2) begin @(posedge clk); #1; end
    chk("midrst_no_pulse", n_done - d0, 0);
    run_op(8'h0F, 8'h01, 1'b0, 0, 0);

    for (int i = 0; i < 20; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 0);

`ifdef SERIAL_ADDER_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, 0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0);
    begin
      int n;
      s1_a = 1'b1; s1_b = 1'b0; s1_c = 1'b1; s1_start = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0;
      n = 0;
      while (n <= 6) begin
        @(posedge clk); #1; n++;
        if (r1_done) break;
      end
      chk("w1_latency", n, 1);
      chk("w1_sum", r1_sum, 1'b0);
      chk("w1_carry", r1_carry, 1'b1);
      chk("w1_ovf", r1_ovf, ref_ovf(1, 1, 0, 1));
    end
`endif

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
